// File: rtl/mvm_coo_streamer.sv
// COO entry streamer for the sparse MVM accelerator: buffers nonzero (row, col, value)
// entries, streams them under fetch_ready, marks end-of-list, then gathers the 4-word result.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | accept loader entries, wait for start
//   S_SEND    | present entry[rd_ptr], advance on fetch_ready
//   S_LAST    | hold done_list until the accelerator takes it
//   S_COLLECT | store result words y0..y3, watch the inter-word idle timer
module mvm_coo_streamer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    input  logic [1:0]               ld_row,
    input  logic [1:0]               ld_col,
    input  logic [7:0]               ld_value,
    output logic                     ld_ready,
    input  logic                     start,
    output logic                     busy,
    input  logic                     fetch_ready,
    output logic                     sending_cpu,
    output logic                     done_list,
    output logic [1:0]               row_val,
    output logic [1:0]               col_val,
    output logic [7:0]               value,
    input  logic                     sending_out,
    input  logic [7:0]               output_val,
    output logic                     res_valid,
    output logic [31:0]              res_vec,
    output logic [$clog2(DEPTH):0]   entry_count,
    output logic                     err_overflow,
    output logic                     err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_LAST    = 2'd2,
        S_COLLECT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]    row_mem [DEPTH];
    logic [1:0]    col_mem [DEPTH];
    logic [7:0]    val_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   count;
    logic [1:0]    slot_k;
    logic [7:0]    word0, word1, word2;
    logic [TW-1:0] idle_tmr;

    logic full;
    logic do_start, do_load, do_write, do_ovf;
    logic do_xfer, last_xfer, do_done;
    logic word_in, last_word, tmo;

    assign entry_count = count;
    assign rd_nxt      = rd_ptr + AW'(1);
    assign full        = (count == (AW+1)'(DEPTH));

    // start wins over a simultaneous ld_valid
    assign do_start  = (state == S_IDLE) && start;
    assign do_load   = (state == S_IDLE) && !start && ld_valid && (ld_value != 8'd0);
    assign do_write  = do_load && !full;
    assign do_ovf    = do_load && full;
    assign do_xfer   = (state == S_SEND) && fetch_ready;
    assign last_xfer = do_xfer && ({1'b0, rd_ptr} == (count - (AW+1)'(1)));
    assign do_done   = (state == S_LAST) && fetch_ready;
    assign word_in   = (state == S_COLLECT) && sending_out;
    assign last_word = word_in && (slot_k == 2'd3);
    assign tmo       = (state == S_COLLECT) && !sending_out && (idle_tmr == TW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ld_ready    = 1'b0;
        busy        = 1'b1;
        sending_cpu = 1'b0;
        done_list   = 1'b0;
        case (state)
            S_IDLE: begin
                ld_ready = 1'b1;
                busy     = 1'b0;
                if (start) begin
                    state_nxt = (count != '0) ? S_SEND : S_LAST;
                end
            end
            S_SEND: begin
                sending_cpu = 1'b1;
                if (last_xfer) begin
                    state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                done_list = 1'b1;
                if (do_done) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (last_word || tmo) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // entry storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_write) begin
            row_mem[wr_ptr] <= ld_row;
            col_mem[wr_ptr] <= ld_col;
            val_mem[wr_ptr] <= ld_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            row_val      <= '0;
            col_val      <= '0;
            value        <= '0;
            slot_k       <= '0;
            word0        <= '0;
            word1        <= '0;
            word2        <= '0;
            idle_tmr     <= '0;
            res_vec      <= '0;
            res_valid    <= 1'b0;
        end else begin
            res_valid <= last_word;

            if (do_start) begin
                err_overflow <= 1'b0;
                err_timeout  <= 1'b0;
                rd_ptr       <= '0;
                if (count != '0) begin
                    row_val <= row_mem[0];
                    col_val <= col_mem[0];
                    value   <= val_mem[0];
                end
            end

            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + (AW+1)'(1);
            end
            if (do_ovf) begin
                err_overflow <= 1'b1;
            end

            // next entry is preloaded on each transfer so the buses stay registered
            if (do_xfer) begin
                if (last_xfer) begin
                    row_val <= '0;
                    col_val <= '0;
                    value   <= '0;
                end else begin
                    rd_ptr  <= rd_nxt;
                    row_val <= row_mem[rd_nxt];
                    col_val <= col_mem[rd_nxt];
                    value   <= val_mem[rd_nxt];
                end
            end

            if (do_done) begin
                slot_k   <= '0;
                idle_tmr <= TW'(TIMEOUT);
            end

            if (word_in) begin
                slot_k   <= slot_k + 2'd1;
                idle_tmr <= TW'(TIMEOUT);
                if (slot_k == 2'd0) word0 <= output_val;
                if (slot_k == 2'd1) word1 <= output_val;
                if (slot_k == 2'd2) word2 <= output_val;
                if (last_word) begin
                    res_vec <= {output_val, word2, word1, word0};
                end
            end else if (state == S_COLLECT) begin
                idle_tmr <= idle_tmr - TW'(1);
            end

            if (tmo) begin
                err_timeout <= 1'b1;
            end
            if (last_word || tmo) begin
                count  <= '0;
                wr_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mvm_coo_streamer.sv
// Directed bench for mvm_coo_streamer: loader tables, streaming with stalls, result
// collection, overflow, timeout and mid-run reset.
module tb_mvm_coo_streamer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [1:0]  ld_row, ld_col;
    logic [7:0]  ld_value;
    logic        ld_ready, start, busy, fetch_ready, sending_cpu, done_list;
    logic [1:0]  row_val, col_val;
    logic [7:0]  value;
    logic        sending_out;
    logic [7:0]  output_val;
    logic        res_valid;
    logic [31:0] res_vec;
    logic [4:0]  entry_count;
    logic        err_overflow, err_timeout;

    mvm_coo_streamer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_row(ld_row), .ld_col(ld_col),
        .ld_value(ld_value), .ld_ready(ld_ready), .start(start), .busy(busy),
        .fetch_ready(fetch_ready), .sending_cpu(sending_cpu), .done_list(done_list),
        .row_val(row_val), .col_val(col_val), .value(value), .sending_out(sending_out),
        .output_val(output_val), .res_valid(res_valid), .res_vec(res_vec),
        .entry_count(entry_count), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [1:0] row;
        logic [1:0] col;
        logic [7:0] val;
        logic [4:0] exp_count;
        logic       exp_ovf;
    } ld_vec_t;

    ld_vec_t     ld_tab [3];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] xfer_q [$];
    int          done_cnt = 0;
    int          res_cnt  = 0;
    logic        stall_prev = 1'b0;
    logic [11:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // transfers happen on the next rising edge; observe them mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_bus_hold", {20'd0, row_val, col_val, value}, {20'd0, held});
                check("stall_sending_hold", {31'd0, sending_cpu}, 32'd1);
            end
            if (sending_cpu && fetch_ready) xfer_q.push_back({row_val, col_val, value});
            if (done_list && fetch_ready) done_cnt++;
            if (res_valid) res_cnt++;
            stall_prev = sending_cpu && !fetch_ready;
            held       = {row_val, col_val, value};
        end
    end

    task automatic apply_ld_tab();
        for (int i = 0; i < 3; i++) begin
            ld_valid = ld_tab[i].vld;
            ld_row   = ld_tab[i].row;
            ld_col   = ld_tab[i].col;
            ld_value = ld_tab[i].val;
            step();
            check($sformatf("ld_count[%0d]", i), {27'd0, entry_count}, {27'd0, ld_tab[i].exp_count});
            check($sformatf("ld_ovf[%0d]", i), {31'd0, err_overflow}, {31'd0, ld_tab[i].exp_ovf});
            check($sformatf("ld_ready[%0d]", i), {31'd0, ld_ready}, 32'd1);
        end
        ld_valid = 1'b0;
    endtask

    task automatic run_stream(input bit toggle, input int exp_n, input int pre_stall);
        bit reached;
        xfer_q.delete();
        done_cnt    = 0;
        fetch_ready = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_ld_ready", {31'd0, ld_ready}, 32'd0);
        for (int i = 0; i < pre_stall; i++) begin
            step();
            check("prestall_sending", {31'd0, sending_cpu}, {31'd0, exp_n > 0});
            check("prestall_done", {31'd0, done_list}, {31'd0, exp_n == 0});
        end
        reached = 1'b0;
        for (int c = 0; c < 400; c++) begin
            fetch_ready = toggle ? (c % 2 == 0) : 1'b1;
            step();
            if (done_cnt != 0) begin
                reached = 1'b1;
                break;
            end
        end
        fetch_ready = 1'b0;
        check("done_reached", {31'd0, reached}, 32'd1);
        check("done_drops", {31'd0, done_list}, 32'd0);
        check("no_send_in_collect", {31'd0, sending_cpu}, 32'd0);
        step();
        check("done_once", done_cnt, 32'd1);
        check("xfer_count", xfer_q.size(), exp_n);
    endtask

    task automatic feed(input logic [31:0] words, input int gap, input logic [31:0] exp);
        int r0;
        r0 = res_cnt;
        for (int k = 0; k < 4; k++) begin
            sending_out = 1'b1;
            output_val  = words[8*k +: 8];
            step();
            sending_out = 1'b0;
            if (k < 3) begin
                check("no_early_res_valid", {31'd0, res_valid}, 32'd0);
                for (int g = 0; g < gap; g++) begin
                    step();
                    check("busy_in_gap", {31'd0, busy}, 32'd1);
                end
            end
        end
        check("res_valid", {31'd0, res_valid}, 32'd1);
        check("res_vec", res_vec, exp);
        check("idle_after_res", {31'd0, busy}, 32'd0);
        check("emptied_after_res", {27'd0, entry_count}, 32'd0);
        step();
        check("res_valid_one_cycle", {31'd0, res_valid}, 32'd0);
        check("res_pulse_count", res_cnt, r0 + 1);
    endtask

    initial begin
        int n;
        int r0;
        logic [1:0] er, ec;
        logic [7:0] ev;

        ld_tab[0] = '{vld: 1'b1, row: 2'd0, col: 2'd1, val: 8'd5, exp_count: 5'd1, exp_ovf: 1'b0};
        ld_tab[1] = '{vld: 1'b1, row: 2'd2, col: 2'd3, val: 8'd9, exp_count: 5'd2, exp_ovf: 1'b0};
        ld_tab[2] = '{vld: 1'b1, row: 2'd1, col: 2'd0, val: 8'd0, exp_count: 5'd2, exp_ovf: 1'b0};

        rst = 1'b1; ld_valid = 1'b0; ld_row = '0; ld_col = '0; ld_value = '0;
        start = 1'b0; fetch_ready = 1'b0; sending_out = 1'b0; output_val = '0;
        step();
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sending", {31'd0, sending_cpu}, 32'd0);
        check("rst_done", {31'd0, done_list}, 32'd0);
        check("rst_res_vec", res_vec, 32'd0);
        check("rst_count", {27'd0, entry_count}, 32'd0);
        check("rst_errs", {30'd0, err_overflow, err_timeout}, 32'd0);
        rst = 1'b0;
        step();

        // basic stream
        apply_ld_tab();
        run_stream(1'b0, 2, 0);
        check("t1_x0", {20'd0, xfer_q[0]}, {20'd0, 2'd0, 2'd1, 8'd5});
        check("t1_x1", {20'd0, xfer_q[1]}, {20'd0, 2'd2, 2'd3, 8'd9});
        feed(32'h0009_0005, 0, 32'h0009_0005);

        // stalled stream with result gaps
        apply_ld_tab();
        run_stream(1'b1, 2, 2);
        check("t2_x0", {20'd0, xfer_q[0]}, {20'd0, 2'd0, 2'd1, 8'd5});
        check("t2_x1", {20'd0, xfer_q[1]}, {20'd0, 2'd2, 2'd3, 8'd9});
        feed(32'h4030_2010, 3, 32'h4030_2010);

        // empty buffer: straight to end-of-list
        run_stream(1'b0, 0, 4);
        feed(32'hDDCC_BBAA, 0, 32'hDDCC_BBAA);

        // overflow
        for (int i = 0; i <= DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_row   = 2'(i % 4);
            ld_col   = 2'((i / 4) % 4);
            ld_value = 8'(i + 1);
            step();
            check("ovf_count", {27'd0, entry_count}, (i < DEPTH) ? i + 1 : DEPTH);
            check("ovf_flag", {31'd0, err_overflow}, {31'd0, i == DEPTH});
        end
        ld_valid = 1'b0;
        fetch_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ovf_cleared_by_start", {31'd0, err_overflow}, 32'd0);
        check("ovf_first_entry", {20'd0, row_val, col_val, value}, {20'd0, 2'd0, 2'd0, 8'd1});
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_row   = 2'(i % 4);
            ld_col   = 2'((i / 4) % 4);
            ld_value = 8'(i + 1);
            step();
        end
        ld_valid = 1'b0;
        check("ovf2_count", {27'd0, entry_count}, DEPTH);
        run_stream(1'b0, DEPTH, 0);
        for (int i = 0; i < DEPTH; i++) begin
            er = 2'(i % 4);
            ec = 2'((i / 4) % 4);
            ev = 8'(i + 1);
            if (i < xfer_q.size())
                check($sformatf("ovf_x%0d", i), {20'd0, xfer_q[i]}, {20'd0, er, ec, ev});
        end
        feed(32'h0403_0201, 1, 32'h0403_0201);

        // timeout in COLLECT
        ld_valid = 1'b1; ld_row = 2'd1; ld_col = 2'd1; ld_value = 8'd7;
        step();
        ld_valid = 1'b0;
        run_stream(1'b0, 1, 0);
        r0 = res_cnt;
        for (int k = 0; k < 2; k++) begin
            sending_out = 1'b1;
            output_val  = 8'h11 * (k + 1);
            step();
        end
        sending_out = 1'b0;
        n = 0;
        while (busy && n < 600) begin
            step();
            n++;
        end
        check("tmo_cycles", n, TIMEOUT);
        check("tmo_flag", {31'd0, err_timeout}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_res_vec_kept", res_vec, 32'h0403_0201);
        check("tmo_no_res_valid", res_cnt, r0);
        check("tmo_emptied", {27'd0, entry_count}, 32'd0);
        sending_out = 1'b1;
        step();
        sending_out = 1'b0;
        check("ignore_sending_out_idle", {31'd0, busy}, 32'd0);

        // reset during SEND
        apply_ld_tab();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("mid_sending", {31'd0, sending_cpu}, 32'd1);
        check("tmo_cleared_by_start", {31'd0, err_timeout}, 32'd0);
        rst = 1'b1;
        step();
        check("mid_rst_outputs", {19'd0, sending_cpu, done_list, busy, res_valid, row_val, col_val, value},
              32'd0);
        check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("mid_rst_count", {27'd0, entry_count}, 32'd0);
        check("mid_rst_res_vec", res_vec, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_no_done", {31'd0, done_list}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
